// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target endpoint with a 16 x 8-bit register file.
// Define I2C_TGT_STRETCH_EN to add SCL stretching ahead of read bytes.
module i2c_target_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
`ifdef I2C_TGT_STRETCH_EN
  , parameter logic [7:0] STRETCH_CYC = 8'd64
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oen,
  output logic       scl_oen,
  output logic       wr_pulse,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] loc_addr,
  output logic [7:0] loc_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] scl_sy, sda_sy;
  logic       scl_q, sda_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start, stop;
  logic [6:0] sreg;
  logic [7:0] rx_byte;
  logic [2:0] cnt;
  logic       phase;
  logic       rw;
  logic [3:0] ptr, ptr_inc;
  logic [7:0] regs [16];
  logic [7:0] rd_src;
  logic       bit_done, ack_end;
  logic       load_rd;
  logic       sda_nxt;

  assign scl_s    = scl_sy[1];
  assign sda_s    = sda_sy[1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & ~sda_s & sda_q;
  assign stop     = scl_s & scl_q & sda_s & ~sda_q;
  assign rx_byte  = {sreg, sda_s};
  assign bit_done = scl_rise & (cnt == 3'd7);
  assign ack_end  = scl_fall & phase;
  assign ptr_inc  = ptr + 4'd1;
  assign rd_src   = (state_q == RACK) ? regs[ptr_inc] : regs[ptr];
  assign load_rd  = ack_end & ~start & ~stop &
                    ((state_q == ADDR_ACK & rw) |
                     (state_q == RACK));

  // Pin synchronizers plus one edge-detect flop per line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], scl_in};
      sda_sy <= {sda_sy[0], sda_in};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state; bus START/STOP win over everything
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR:
          if (bit_done)
            state_d = (rx_byte[7:1] == SLAVE_ADDR)
                      ? ADDR_ACK : IDLE;
        ADDR_ACK:
          if (ack_end) state_d = rw ? RDATA : PTR;
        PTR:
          if (bit_done)
            state_d = (rx_byte[7:4] == 4'd0)
                      ? PTR_ACK : IDLE;
        PTR_ACK:
          if (ack_end) state_d = WDATA;
        WDATA:
          if (bit_done) state_d = WDATA_ACK;
        WDATA_ACK:
          if (ack_end) state_d = WDATA;
        RDATA:
          if (bit_done) state_d = RACK;
        RACK:
          if (scl_rise && sda_s) state_d = IDLE;
          else if (ack_end)      state_d = RDATA;
        default: state_d = IDLE;
      endcase
    end
  end

  // SDA drive level; it only moves on a detected SCL fall
  always_comb begin
    sda_nxt = sda_oen;
    if (start || stop) begin
      sda_nxt = 1'b1;
    end else if (scl_fall) begin
      unique case (state_q)
        ADDR_ACK, PTR_ACK, WDATA_ACK:
          sda_nxt = phase ? (load_rd ? rd_src[7] : 1'b1)
                          : 1'b0;
        RDATA:   sda_nxt = sreg[6];
        RACK:    sda_nxt = phase ? rd_src[7] : 1'b1;
        default: sda_nxt = 1'b1;
      endcase
    end
  end

  // Shifter, bit counter, pointer, register file and write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sda_oen  <= 1'b1;
      sreg     <= 7'd0;
      cnt      <= 3'd0;
      phase    <= 1'b0;
      rw       <= 1'b0;
      ptr      <= 4'd0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= 4'd0;
      wr_data  <= 8'd0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      sda_oen  <= sda_nxt;
      wr_pulse <= 1'b0;
      if (stop || start) begin
        busy  <= 1'b0;
        cnt   <= 3'd0;
        phase <= 1'b0;
      end else begin
        unique case (state_q)
          ADDR: if (scl_rise) begin
            sreg  <= rx_byte[6:0];
            cnt   <= cnt + 3'd1;
            phase <= 1'b0;
            if (bit_done) begin
              rw <= sda_s;
              if (rx_byte[7:1] == SLAVE_ADDR) busy <= 1'b1;
            end
          end
          PTR: if (scl_rise) begin
            sreg  <= rx_byte[6:0];
            cnt   <= cnt + 3'd1;
            phase <= 1'b0;
            if (bit_done && rx_byte[7:4] == 4'd0)
              ptr <= rx_byte[3:0];
          end
          WDATA: if (scl_rise) begin
            sreg  <= rx_byte[6:0];
            cnt   <= cnt + 3'd1;
            phase <= 1'b0;
            if (bit_done) begin
              regs[ptr] <= rx_byte;
              wr_pulse  <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_byte;
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_rise) phase <= 1'b1;
            if (ack_end) begin
              phase <= 1'b0;
              if (state_q == WDATA_ACK) ptr <= ptr_inc;
              if (load_rd) sreg <= rd_src[6:0];
            end
          end
          RDATA: begin
            if (scl_rise) begin
              cnt   <= cnt + 3'd1;
              phase <= 1'b0;
            end
            if (scl_fall) sreg <= {sreg[5:0], 1'b0};
          end
          RACK: begin
            if (scl_rise) phase <= 1'b1;
            if (ack_end) begin
              phase <= 1'b0;
              ptr   <= ptr_inc;
              sreg  <= rd_src[6:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Local read port, one clock of latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) loc_rdata <= 8'h00;
    else      loc_rdata <= regs[loc_addr];
  end

`ifdef I2C_TGT_STRETCH_EN
  logic       scl_hold;
  logic [7:0] st_cnt;

  // Hold SCL low for STRETCH_CYC clocks ahead of each read byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hold <= 1'b0;
      st_cnt   <= 8'd0;
    end else if (start || stop) begin
      scl_hold <= 1'b0;
    end else if (load_rd) begin
      scl_hold <= 1'b1;
      st_cnt   <= STRETCH_CYC - 8'd1;
    end else if (scl_hold) begin
      if (st_cnt == 8'd0) scl_hold <= 1'b0;
      else                st_cnt   <= st_cnt - 8'd1;
    end
  end

  assign scl_oen = ~scl_hold;
`else
  assign scl_oen = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bus-level bench for i2c_target_regs.
// Open-drain lines are modelled as wired-AND of master and target.
module tb_i2c_target_regs;

  localparam int Q = 6;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_line, sda_line;
  logic       sda_oen, scl_oen, wr_pulse, busy;
  logic [3:0] wr_addr;
  logic [3:0] loc_addr = 4'd0;
  logic [7:0] wr_data, loc_rdata;

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] wr_log[$];
  int sda_low_cnt = 0;
  int run = 0;
  int last_run = 0;

  assign scl_line = scl_m & scl_oen;
  assign sda_line = sda_m & sda_oen;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_line),
    .sda_in    (sda_line),
    .sda_oen   (sda_oen),
    .scl_oen   (scl_oen),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .loc_addr  (loc_addr),
    .loc_rdata (loc_rdata),
    .busy      (busy)
  );

  // Record write strobes, SDA pull-downs and SCL stretch lengths
  always @(negedge clk) begin
    if (wr_pulse) wr_log.push_back({wr_addr, wr_data});
    if (!sda_oen) sda_low_cnt++;
    if (!scl_oen) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_m = 1'b1;
    wait_clk(1);
    while (!scl_line && t < 2000) begin
      wait_clk(1);
      t++;
    end
    if (!scl_line) check("scl_release", scl_line, 1'b1);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;
    wait_clk(Q);
    scl_high();
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    wait_clk(Q);
    scl_high();
    wait_clk(H / 2);
    b = sda_line;
    wait_clk(H / 2);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_high();
    wait_clk(H);
    sda_m = 1'b0;
    wait_clk(H);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_high();
    wait_clk(H);
    sda_m = 1'b1;
    wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] d,
                           output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d,
                           input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  task automatic loc_read(input logic [3:0] a,
                          input logic [7:0] exp,
                          input string tag);
    loc_addr = a;
    wait_clk(2);
    check(tag, loc_rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         nlow;

    rst = 1'b0;
    wait_clk(4);
    check("rst_sda_oen", sda_oen, 1'b1);
    check("rst_scl_oen", scl_oen, 1'b1);
    check("rst_wr_pulse", wr_pulse, 1'b0);
    check("rst_wr_addr", wr_addr, 4'd0);
    check("rst_wr_data", wr_data, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_loc_rdata", loc_rdata, 8'd0);
    rst = 1'b1;
    wait_clk(4);

    // basic write of two bytes from ptr 3
    i2c_start();
    send_byte(8'hA0, a); check("t1_addr_ack", a, 1'b0);
    send_byte(8'h03, a); check("t1_ptr_ack", a, 1'b0);
    send_byte(8'h11, a); check("t1_d0_ack", a, 1'b0);
    send_byte(8'h22, a); check("t1_d1_ack", a, 1'b0);
    check("t1_busy", busy, 1'b1);
    i2c_stop();
    wait_clk(4);
    check("t1_busy_clr", busy, 1'b0);
    check("t1_npulse", wr_log.size(), 2);
    check("t1_pulse0", wr_log[0], 12'h311);
    check("t1_pulse1", wr_log[1], 12'h422);
    loc_read(4'd4, 8'h22, "t1_reg4");
    loc_read(4'd3, 8'h11, "t1_reg3");

    // pointer wrap 15 -> 0
    i2c_start();
    send_byte(8'hA0, a); check("t2_addr_ack", a, 1'b0);
    send_byte(8'h0F, a); check("t2_ptr_ack", a, 1'b0);
    send_byte(8'hAA, a); check("t2_d0_ack", a, 1'b0);
    send_byte(8'hBB, a); check("t2_d1_ack", a, 1'b0);
    i2c_stop();
    wait_clk(4);
    check("t2_pulse0", wr_log[2], 12'hFAA);
    check("t2_pulse1", wr_log[3], 12'h0BB);
    loc_read(4'd15, 8'hAA, "t2_reg15");
    loc_read(4'd0, 8'hBB, "t2_reg0");

    // wrong address: never pulls SDA
    nlow = sda_low_cnt;
    i2c_start();
    send_byte(8'hA2, a); check("t3_addr_nack", a, 1'b1);
    check("t3_busy", busy, 1'b0);
    send_byte(8'h55, a); check("t3_data_nack", a, 1'b1);
    i2c_stop();
    wait_clk(4);
    check("t3_sda_low", sda_low_cnt - nlow, 0);
    check("t3_npulse", wr_log.size(), 4);

    // reg2 = 5C, then pointer write, repeated START, read 2
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h02, a);
    send_byte(8'h5C, a); check("t4_w_ack", a, 1'b0);
    i2c_stop();
    wait_clk(4);
    check("t4_pulse", wr_log[4], 12'h25C);
    i2c_start();
    send_byte(8'hA0, a); check("t4_addr_ack", a, 1'b0);
    send_byte(8'h02, a); check("t4_ptr_ack", a, 1'b0);
    i2c_start();
    send_byte(8'hA1, a); check("t4_raddr_ack", a, 1'b0);
    recv_byte(d, 1'b0);  check("t4_rd0", d, 8'h5C);
    recv_byte(d, 1'b1);  check("t4_rd1", d, 8'h11);
    check("t4_sda_rel", sda_oen, 1'b1);
    read_bit(a);         check("t4_idle_bit", a, 1'b1);
    i2c_stop();
    wait_clk(4);
    check("t4_npulse", wr_log.size(), 5);

    // pointer out of range: NACK, following byte ignored
    i2c_start();
    send_byte(8'hA0, a); check("t5_addr_ack", a, 1'b0);
    send_byte(8'h20, a); check("t5_ptr_nack", a, 1'b1);
    send_byte(8'h77, a); check("t5_data_nack", a, 1'b1);
    i2c_stop();
    wait_clk(4);
    check("t5_npulse", wr_log.size(), 5);
    loc_read(4'd0, 8'hBB, "t5_reg0");
    check("t5_wr_addr", wr_addr, 4'd2);
    check("t5_wr_data", wr_data, 8'h5C);

`ifdef I2C_TGT_STRETCH_EN
    // read reg3 with a stretch ahead of the byte
    i2c_start();
    send_byte(8'hA1, a); check("t6_addr_ack", a, 1'b0);
    recv_byte(d, 1'b1);  check("t6_rd", d, 8'h11);
    check("t6_stretch_len", last_run, 64);
    i2c_stop();
    wait_clk(4);

    // reset in the middle of a stretch
    i2c_start();
    send_byte(8'hA1, a); check("t7_addr_ack", a, 1'b0);
    wait_clk(10);
    check("t7_stretching", scl_oen, 1'b0);
    check("t7_sda_drv", sda_oen, 1'b0);
    rst = 1'b0;
    #1;
    check("t7_rst_scl", scl_oen, 1'b1);
    check("t7_rst_sda", sda_oen, 1'b1);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    loc_read(4'd3, 8'h00, "t7_reg3_clr");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
